// File: rtl/vga_sync_decoder_pkg.sv
// -----------------------------------------------------------------------------
// vga_sync_decoder_pkg
//
// Shared constants and types for the VGA sync decoder:
//   - 640x480@60 timing constants used as the decoder's parameter defaults
//   - coordinate / error-counter widths
//   - FSM state encoding for the lock tracker
//   - saturating increment helpers
//
// Optional feature macro used by the decoder: SYNC_DECODER_ERR_CNT_EN
// -----------------------------------------------------------------------------
package vga_sync_decoder_pkg;

   // 640x480 timing: clocks per line, lines per frame, visible area.
   localparam int unsigned TotalCols640     = 800;
   localparam int unsigned TotalRows640     = 525;
   localparam int unsigned ActiveCols640    = 640;
   localparam int unsigned ActiveRows640    = 480;

   // Consecutive good lines required before a VSync may establish lock.
   localparam int unsigned LockLinesDefault = 4;

   // Output widths.
   localparam int unsigned CoordW = 10;
   localparam int unsigned ErrW   = 8;

   // Lock tracker states.
   typedef enum logic [1:0] {
      StUnlocked = 2'b00,
      StCheck    = 2'b01,
      StLocked   = 2'b10
   } sync_state_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CoordW-1:0] coord_inc_sat(input logic [CoordW-1:0] value);
      return (value == {CoordW{1'b1}}) ? value : value + {{(CoordW-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [ErrW-1:0] err_inc_sat(input logic [ErrW-1:0] value);
      return (value == {ErrW{1'b1}}) ? value : value + {{(ErrW-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
//
// Two-flop register on an asynchronous active-low sync input plus a
// falling-edge detector. The edge pulse is high for one cycle when the older
// sample (q2) is 1 and the newer sample (q1) is 0.
//
// Both flops reset to 1 (the idle level of an active-low sync), so leaving
// reset never produces a spurious edge.
//
// Ports:
//   clk_i    in   clock
//   rst_i    in   synchronous active-high reset
//   sync_ni  in   active-low sync input
//   fall_o   out  one-cycle falling-edge pulse
// -----------------------------------------------------------------------------
module sync_edge_detect (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sync_ni,
   output logic fall_o
);

   logic q1_q;
   logic q2_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q1_q <= 1'b1;
         q2_q <= 1'b1;
      end else begin
         q1_q <= sync_ni;
         q2_q <= q1_q;
      end
   end

   assign fall_o = q2_q & ~q1_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// vga_sync_decoder
//
// Recovers pixel column / row coordinates from VGA HSync and VSync and tracks
// whether the incoming timing matches the configured format.
//
// Parameters:
//   TOTAL_COLS   clocks per line            (default 800)
//   TOTAL_ROWS   lines per frame            (default 525)
//   ACTIVE_COLS  visible columns            (default 640)
//   ACTIVE_ROWS  visible rows               (default 480)
//   LOCK_LINES   good lines needed to lock  (default 4)
//
// Ports:
//   i_Clk          in   pixel clock
//   i_Reset        in   synchronous active-high reset
//   i_VGA_HSync    in   horizontal sync, active-low
//   i_VGA_VSync    in   vertical sync, active-low
//   o_Col          out  recovered column (saturates at 1023)
//   o_Row          out  recovered row (saturates at 1023)
//   o_Line_Start   out  one-cycle pulse, coincides with o_Col loading 0
//   o_Frame_Start  out  one-cycle pulse, coincides with o_Row loading 0 while
//                       lock is held
//   o_Active       out  locked and inside the visible area
//   o_Locked       out  timing lock
//   o_Err_Count    out  number of lock losses (saturates at 255)
//
// Optional feature: define SYNC_DECODER_ERR_CNT_EN to enable the lock-loss
// counter; otherwise o_Err_Count is tied to 0 but the port remains.
// -----------------------------------------------------------------------------
module vga_sync_decoder
   import vga_sync_decoder_pkg::*;
#(
   parameter int unsigned TOTAL_COLS  = TotalCols640,
   parameter int unsigned TOTAL_ROWS  = TotalRows640,
   parameter int unsigned ACTIVE_COLS = ActiveCols640,
   parameter int unsigned ACTIVE_ROWS = ActiveRows640,
   parameter int unsigned LOCK_LINES  = LockLinesDefault
) (
   input  logic              i_Clk,
   input  logic              i_Reset,
   input  logic              i_VGA_HSync,
   input  logic              i_VGA_VSync,
   output logic [CoordW-1:0] o_Col,
   output logic [CoordW-1:0] o_Row,
   output logic              o_Line_Start,
   output logic              o_Frame_Start,
   output logic              o_Active,
   output logic              o_Locked,
   output logic [ErrW-1:0]   o_Err_Count
);

   // Good-line counter only needs to reach LOCK_LINES.
   localparam int unsigned CntW = (LOCK_LINES < 1) ? 1 : $clog2(LOCK_LINES + 1);

   localparam logic [CoordW-1:0] LastCol = CoordW'(TOTAL_COLS - 1);
   localparam logic [CoordW-1:0] LastRow = CoordW'(TOTAL_ROWS - 1);
   localparam logic [CoordW-1:0] ActCols = CoordW'(ACTIVE_COLS);
   localparam logic [CoordW-1:0] ActRows = CoordW'(ACTIVE_ROWS);
   localparam logic [CntW-1:0]   LockCnt = CntW'(LOCK_LINES);

   logic h_edge;
   logic v_edge;

   logic [CoordW-1:0] col_q, col_d;
   logic [CoordW-1:0] row_q, row_d;
   logic              line_start_q;
   logic              frame_start_q, frame_start_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   sync_state_e       state_q, state_d;

   logic at_last_col;
   logic good_line;
   logic bad_line;
   logic lock_lost;

   // ---------------------------------------------------------------------------
   // Sync input registration and edge detection
   // ---------------------------------------------------------------------------
   sync_edge_detect u_hsync_edge (
      .clk_i   (i_Clk),
      .rst_i   (i_Reset),
      .sync_ni (i_VGA_HSync),
      .fall_o  (h_edge)
   );

   sync_edge_detect u_vsync_edge (
      .clk_i   (i_Clk),
      .rst_i   (i_Reset),
      .sync_ni (i_VGA_VSync),
      .fall_o  (v_edge)
   );

   // ---------------------------------------------------------------------------
   // Line qualification
   // ---------------------------------------------------------------------------
   // A line is good only when the HSync edge lands exactly on the last column.
   // An edge anywhere else is early; reaching the last column with no edge
   // means the column would run past TOTAL_COLS, which is an overrun.
   assign at_last_col = (col_q == LastCol);
   assign good_line   = h_edge & at_last_col;
   assign bad_line    = h_edge ^ at_last_col;

   // ---------------------------------------------------------------------------
   // Coordinate counters
   // ---------------------------------------------------------------------------
   always_comb begin
      col_d = coord_inc_sat(col_q);
      row_d = row_q;
      if (h_edge) begin
         col_d = '0;
         row_d = coord_inc_sat(row_q);
      end
      // VSync wins over the HSync row increment when both arrive together.
      if (v_edge) begin
         row_d = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // Lock tracker FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lock_lost = 1'b0;

      unique case (state_q)
         StUnlocked: begin
            if (h_edge) begin
               state_d = StCheck;
               cnt_d   = '0;
            end
         end

         StCheck: begin
            if (bad_line) begin
               state_d = StUnlocked;
               cnt_d   = '0;
            end else begin
               if (v_edge && (cnt_q >= LockCnt)) begin
                  state_d = StLocked;
               end
               if (good_line && (cnt_q < LockCnt)) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         StLocked: begin
            if (bad_line || (v_edge && (row_q != LastRow))) begin
               state_d   = StUnlocked;
               cnt_d     = '0;
               lock_lost = 1'b1;
            end
         end

         default: begin
            state_d = StUnlocked;
            cnt_d   = '0;
         end
      endcase
   end

   // Frame start only for a VSync that keeps an existing lock; the edge that
   // breaks lock, or the one that first establishes it, does not pulse.
   always_comb begin
      frame_start_d = v_edge & (state_q == StLocked) & ~lock_lost;
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         col_q         <= '0;
         row_q         <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         cnt_q         <= '0;
         state_q       <= StUnlocked;
      end else begin
         col_q         <= col_d;
         row_q         <= row_d;
         line_start_q  <= h_edge;
         frame_start_q <= frame_start_d;
         cnt_q         <= cnt_d;
         state_q       <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Lock-loss counter
   // ---------------------------------------------------------------------------
`ifdef SYNC_DECODER_ERR_CNT_EN
   logic [ErrW-1:0] err_q;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         err_q <= '0;
      end else if (lock_lost) begin
         err_q <= err_inc_sat(err_q);
      end
   end

   assign o_Err_Count = err_q;
`else
   assign o_Err_Count = '0;
`endif

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign o_Col         = col_q;
   assign o_Row         = row_q;
   assign o_Line_Start  = line_start_q;
   assign o_Frame_Start = frame_start_q;
   assign o_Locked      = (state_q == StLocked);
   assign o_Active      = o_Locked && (col_q < ActCols) && (row_q < ActRows);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_decoder
//
// Directed bench for vga_sync_decoder. Lines keep the 800-clock width; the
// frame height is shortened to 20 lines (12 visible) so whole frames fit in a
// short run. Stimulus pushes timestamped expectations into a scoreboard and a
// negedge monitor compares every output selected by each entry's mask.
// Timestamps count rising clock edges; an input changed just after edge k is
// sampled at edge k+1 and its edge pulse acts at edge k+2.
// -----------------------------------------------------------------------------
module tb_vga_sync_decoder;

   localparam int unsigned TotCols   = 800;
   localparam int unsigned TotRows   = 20;
   localparam int unsigned ActCols   = 640;
   localparam int unsigned ActRows   = 12;
   localparam int unsigned LockLines = 4;

`ifdef SYNC_DECODER_ERR_CNT_EN
   localparam int ErrInc = 1;
`else
   localparam int ErrInc = 0;
`endif

   localparam logic [6:0] MCol = 7'd1;
   localparam logic [6:0] MRow = 7'd2;
   localparam logic [6:0] MLs  = 7'd4;
   localparam logic [6:0] MFs  = 7'd8;
   localparam logic [6:0] MAct = 7'd16;
   localparam logic [6:0] MLk  = 7'd32;
   localparam logic [6:0] MErr = 7'd64;
   localparam logic [6:0] MAll = 7'h7f;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       hs  = 1'b1;
   logic       vs  = 1'b1;
   logic [9:0] o_col;
   logic [9:0] o_row;
   logic       o_ls;
   logic       o_fs;
   logic       o_act;
   logic       o_lk;
   logic [7:0] o_err;

   vga_sync_decoder #(
      .TOTAL_COLS  (TotCols),
      .TOTAL_ROWS  (TotRows),
      .ACTIVE_COLS (ActCols),
      .ACTIVE_ROWS (ActRows),
      .LOCK_LINES  (LockLines)
   ) dut (
      .i_Clk         (clk),
      .i_Reset       (rst),
      .i_VGA_HSync   (hs),
      .i_VGA_VSync   (vs),
      .o_Col         (o_col),
      .o_Row         (o_row),
      .o_Line_Start  (o_ls),
      .o_Frame_Start (o_fs),
      .o_Active      (o_act),
      .o_Locked      (o_lk),
      .o_Err_Count   (o_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_err  = 0;

   typedef struct {
      string      name;
      int         stamp;
      logic [6:0] mask;
      int         col;
      int         row;
      int         ls;
      int         fs;
      int         act;
      int         lk;
      int         err;
   } exp_t;

   exp_t sb[$];

   task automatic sb_push(input string name, input int stamp, input logic [6:0] mask,
                          input int col, input int row, input int ls, input int fs,
                          input int act, input int lk, input int err);
      exp_t e;
      e.name  = name;
      e.stamp = stamp;
      e.mask  = mask;
      e.col   = col;
      e.row   = row;
      e.ls    = ls;
      e.fs    = fs;
      e.act   = act;
      e.lk    = lk;
      e.err   = err;
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input string field, input int got, input int want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s.%s at cycle %0d: got %0d, want %0d", name, field, cyc, got, want);
   endtask

   // Monitor: compare every scoreboard entry due on this cycle.
   always @(negedge clk) begin
      exp_t e;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].stamp == cyc) begin
            e = sb[i];
            if (e.mask[0]) chk(e.name, "col",    int'(o_col), e.col);
            if (e.mask[1]) chk(e.name, "row",    int'(o_row), e.row);
            if (e.mask[2]) chk(e.name, "line",   int'(o_ls),  e.ls);
            if (e.mask[3]) chk(e.name, "frame",  int'(o_fs),  e.fs);
            if (e.mask[4]) chk(e.name, "active", int'(o_act), e.act);
            if (e.mask[5]) chk(e.name, "locked", int'(o_lk),  e.lk);
            if (e.mask[6]) chk(e.name, "err",    int'(o_err), e.err);
            sb.delete(i);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One line starting with an HSync fall (96 clocks low). vs_pos / rst_pos
   // place a 4-clock VSync low pulse / 1-clock reset pulse within the line.
   task automatic run_line(input int len, input int vs_pos, input int rst_pos);
      for (int i = 0; i < len; i++) begin
         hs  = (i < 96) ? 1'b0 : 1'b1;
         vs  = (vs_pos >= 0 && i >= vs_pos && i < vs_pos + 4) ? 1'b0 : 1'b1;
         rst = (i == rst_pos) ? 1'b1 : 1'b0;
         step();
      end
   endtask

   initial begin
      int b;

      // Reset held over edges 1..3, released afterwards; no false edge follows.
      sb_push("reset", 3, MAll, 0, 0, 0, 0, 0, 0, 0);
      sb_push("post_reset_idle", 6, MCol | MRow | MLs | MLk, 3, 0, 0, 0, 0, 0, 0);
      repeat (3) step();
      rst = 1'b0;
      repeat (7) step();

      // Lines 1..5 acquire the good-line count; line 6 carries the locking VSync.
      for (int l = 1; l <= 5; l++) begin
         b = cyc;
         if (l == 1) sb_push("first_line", b + 2, MCol | MRow | MLs | MLk, 0, 1, 1, 0, 0, 0, 0);
         if (l == 5) sb_push("check_no_lock", b + 2, MRow | MLk, 0, 5, 0, 0, 0, 0, 0);
         run_line(800, -1, -1);
      end
      b = cyc;
      sb_push("lock_pre", b + 201, MLk, 0, 0, 0, 0, 0, 0, 0);
      sb_push("lock", b + 202, MCol | MRow | MAct | MLk | MErr, 200, 0, 0, 0, 1, 1, 0);
      run_line(800, 200, -1);

      // Lines 7..24 are rows 1..18 of the frame.
      for (int l = 7; l <= 24; l++) begin
         b = cyc;
         if (l == 7)
            sb_push("locked_line_start", b + 2, MCol | MRow | MLs | MFs | MLk, 0, 1, 1, 0, 0, 1, 0);
         if (l == 16) begin
            sb_push("active_c639", b + 641, MCol | MRow | MAct, 639, 10, 0, 0, 1, 0, 0);
            sb_push("active_c640", b + 642, MCol | MAct, 640, 10, 0, 0, 0, 0, 0);
         end
         if (l == 18) begin
            sb_push("row12_c0", b + 2, MRow | MAct | MLk, 0, 12, 0, 0, 0, 1, 0);
            sb_push("row12_c298", b + 300, MRow | MAct | MLk, 0, 12, 0, 0, 0, 1, 0);
            sb_push("row12_c698", b + 700, MRow | MAct | MLk, 0, 12, 0, 0, 0, 1, 0);
         end
         run_line(800, -1, -1);
      end

      // Line 25 is row 19: a correctly placed VSync keeps lock and pulses frame.
      b = cyc;
      sb_push("frame_pre", b + 201, MRow | MFs | MLk, 0, 19, 0, 0, 0, 1, 0);
      sb_push("frame", b + 202, MCol | MRow | MFs | MLk, 200, 0, 0, 1, 0, 1, 0);
      sb_push("frame_pulse_end", b + 203, MCol | MFs, 201, 0, 0, 0, 0, 0, 0);
      run_line(800, 200, -1);

      // Lines 26..44 reach row 19; line 45 has HSync and VSync falling together.
      for (int l = 26; l <= 44; l++) run_line(800, -1, -1);
      b = cyc;
      sb_push("both_edges", b + 2, MCol | MRow | MLs | MFs | MLk, 0, 0, 1, 1, 0, 1, 0);
      sb_push("both_edges_end", b + 3, MCol | MLs | MFs, 1, 0, 0, 0, 0, 0, 0);
      run_line(800, 0, -1);

      // VSync on row 2 breaks lock without a frame pulse.
      run_line(800, -1, -1);
      b = cyc;
      exp_err += ErrInc;
      sb_push("vs_bad_pre", b + 301, MRow | MLk, 0, 2, 0, 0, 0, 1, 0);
      sb_push("vs_bad", b + 302, MRow | MFs | MAct | MLk | MErr, 0, 0, 0, 0, 0, 0, exp_err);
      run_line(800, 300, -1);

      // Relock: line 48 enters check, 49..52 good, VSync in line 53.
      for (int l = 48; l <= 52; l++) run_line(800, -1, -1);
      b = cyc;
      sb_push("relock_pre", b + 101, MLk, 0, 0, 0, 0, 0, 0, 0);
      sb_push("relock", b + 102, MLk, 0, 0, 0, 0, 0, 1, 0);
      run_line(800, 100, -1);

      // Early HSync at column 700 breaks lock; then HSync stays high ~1200 clocks.
      run_line(800, -1, -1);
      run_line(701, -1, -1);
      b = cyc;
      exp_err += ErrInc;
      sb_push("early_pre", b + 1, MCol | MLk, 700, 0, 0, 0, 0, 1, 0);
      sb_push("early", b + 2, MCol | MLs | MLk | MErr, 0, 0, 1, 0, 0, 0, exp_err);
      sb_push("col_pre_sat", b + 1024, MCol, 1022, 0, 0, 0, 0, 0, 0);
      sb_push("col_sat", b + 1025, MCol | MLk, 1023, 0, 0, 0, 0, 0, 0);
      sb_push("col_sat_hold", b + 1299, MCol | MLk, 1023, 0, 0, 0, 0, 0, 0);
      run_line(1300, -1, -1);

      // Relock again (lines 57..62), then reset mid-line 63 (row 1, col 398).
      for (int l = 57; l <= 61; l++) run_line(800, -1, -1);
      b = cyc;
      sb_push("relock2", b + 102, MLk, 0, 0, 0, 0, 0, 1, 0);
      run_line(800, 100, -1);
      b = cyc;
      sb_push("rst_pre", b + 400, MCol | MRow | MAct | MLk | MErr, 398, 1, 0, 0, 1, 1, exp_err);
      sb_push("rst_mid", b + 401, MAll, 0, 0, 0, 0, 0, 0, 0);
      exp_err = 0;
      sb_push("post_rst", b + 450, MCol | MRow | MLs | MLk | MErr, 49, 0, 0, 0, 0, 0, exp_err);
      run_line(500, -1, 400);

      repeat (5) step();
      n_checks++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
